// File: rtl/ob_cmd_arb_if.sv
// Order-book command/response types and the arbiter's bus bundle.
// slave faces the arbiter; master faces the requesters, ob and the bench.
package ob_pkg;
    localparam int UID_W = 8;

    typedef logic [UID_W-1:0] uid_t;

    typedef struct packed {
        uid_t        uid;
        logic [1:0]  op;
        logic [15:0] price;
        logic [15:0] qty;
    } cmd_t;

    typedef struct packed {
        uid_t        uid;
        logic [1:0]  status;
        logic [15:0] qty;
    } rsp_t;
endpackage

interface ob_cmd_arb_if #(parameter int N = 4);
    logic [N-1:0]  req_vld;
    ob_pkg::cmd_t  req_cmd [N];
    logic [N-1:0]  req_accept;
    logic          cmd_vld_r;
    ob_pkg::cmd_t  cmd_r;
    logic          cmd_full_r;
    logic          ob_rsp_vld;
    ob_pkg::rsp_t  ob_rsp;
    logic          ob_rsp_accept;
    logic [N-1:0]  rsp_vld;
    ob_pkg::rsp_t  rsp;
    logic [N-1:0]  rsp_accept;
    logic          err_r;

    modport slave (
        input  req_vld, req_cmd, cmd_full_r, ob_rsp_vld, ob_rsp, rsp_accept,
        output req_accept, cmd_vld_r, cmd_r, ob_rsp_accept, rsp_vld, rsp, err_r
    );

    modport master (
        output req_vld, req_cmd, cmd_full_r, ob_rsp_vld, ob_rsp, rsp_accept,
        input  req_accept, cmd_vld_r, cmd_r, ob_rsp_accept, rsp_vld, rsp, err_r
    );
endinterface

// File: rtl/ob_cmd_arb.sv
// Round-robin arbiter for the order-book command port, with uid port stamping
// and a one-entry registered response router back to the requesters.
module ob_cmd_arb #(
    parameter int N   = 4,
    parameter int P_W = $clog2(N)
) (
    input logic         clk,
    input logic         rst,
    ob_cmd_arb_if.slave bus
);
    localparam int UID_W = $bits(ob_pkg::uid_t);

    logic [P_W-1:0] ptr_r;
    logic [P_W-1:0] ptr_nxt;
    logic [N-1:0]   grant;
    logic           found;
    logic           eligible;
    ob_pkg::cmd_t   cmd_sel;
    int             idx;

    logic [P_W-1:0] rsp_port;
    logic [N-1:0]   rsp_onehot;
    logic           rsp_port_ok;
    logic           out_free;

    // Issuing only while nothing is in flight keeps ob's queue safe despite
    // the one-cycle lag of cmd_full_r.
    assign eligible = ~rst & ~bus.cmd_full_r & ~bus.cmd_vld_r;

    always_comb begin
        grant   = '0;
        found   = 1'b0;
        cmd_sel = '0;
        ptr_nxt = ptr_r;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_r) + k;
            if (idx >= N) idx = idx - N;
            if (!found && bus.req_vld[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                cmd_sel    = bus.req_cmd[idx];
                cmd_sel.uid[UID_W-1 -: P_W] = P_W'(idx);
                ptr_nxt    = (idx == N - 1) ? '0 : P_W'(idx + 1);
            end
        end
    end

    assign bus.req_accept = eligible ? grant : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cmd_vld_r <= 1'b0;
            bus.cmd_r     <= '0;
            ptr_r         <= '0;
        end else begin
            bus.cmd_vld_r <= 1'b0;
            if (eligible && found) begin
                bus.cmd_vld_r <= 1'b1;
                bus.cmd_r     <= cmd_sel;
                ptr_r         <= ptr_nxt;
            end
        end
    end

    // Response side: decode the owning port from the uid MSBs.
    always_comb begin
        rsp_port   = bus.ob_rsp.uid[UID_W-1 -: P_W];
        rsp_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(rsp_port) == i) rsp_onehot[i] = 1'b1;
        end
        rsp_port_ok = |rsp_onehot;
    end

    assign out_free          = ~(|bus.rsp_vld) | (|(bus.rsp_vld & bus.rsp_accept));
    assign bus.ob_rsp_accept = ~rst & bus.ob_rsp_vld & out_free;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rsp_vld <= '0;
            bus.rsp     <= '0;
            bus.err_r   <= 1'b0;
        end else if (bus.ob_rsp_accept) begin
            if (rsp_port_ok) begin
                bus.rsp     <= bus.ob_rsp;
                bus.rsp_vld <= rsp_onehot;
            end else begin
                bus.rsp_vld <= '0;
                bus.err_r   <= 1'b1;
            end
        end else if (out_free) begin
            bus.rsp_vld <= '0;
        end
    end
endmodule

// File: tb/tb_ob_cmd_arb.sv
// Directed bench for ob_cmd_arb: N=4 main instance plus an N=3 instance for
// out-of-range response ports.
module tb_ob_cmd_arb;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    ob_cmd_arb_if #(.N(4)) bus4 ();
    ob_cmd_arb_if #(.N(3)) bus3 ();

    ob_cmd_arb #(.N(4)) dut  (.clk(clk), .rst(rst), .bus(bus4));
    ob_cmd_arb #(.N(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1);
    end

    function automatic ob_pkg::cmd_t mk_cmd(int i);
        ob_pkg::cmd_t c;
        c.uid   = 8'hC0 | 8'(i + 1);
        c.op    = 2'(i);
        c.price = 16'h0100 * 16'(i + 1);
        c.qty   = 16'h0010 + 16'(i);
        return c;
    endfunction

    function automatic ob_pkg::cmd_t exp_cmd(int g);
        ob_pkg::cmd_t c;
        c = mk_cmd(g);
        c.uid[7:6] = 2'(g);
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus4.req_vld    = 4'hF;
        bus4.ob_rsp_vld = 1'b1;
        bus4.ob_rsp     = '{uid: 8'h40, status: 2'd1, qty: 16'h1234};
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus4.cmd_vld_r !== 1'b0) begin n_err++; $display("FAIL reset_cmd_vld got %b want 0", bus4.cmd_vld_r); end
        n_cmp++; if (bus4.cmd_r !== '0) begin n_err++; $display("FAIL reset_cmd got %h want 0", bus4.cmd_r); end
        n_cmp++; if (bus4.rsp_vld !== 4'b0) begin n_err++; $display("FAIL reset_rsp_vld got %b want 0", bus4.rsp_vld); end
        n_cmp++; if (bus4.rsp !== '0) begin n_err++; $display("FAIL reset_rsp got %h want 0", bus4.rsp); end
        n_cmp++; if (bus4.err_r !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", bus4.err_r); end
        n_cmp++; if (bus4.req_accept !== 4'b0) begin n_err++; $display("FAIL reset_req_accept got %b want 0", bus4.req_accept); end
        n_cmp++; if (bus4.ob_rsp_accept !== 1'b0) begin n_err++; $display("FAIL reset_ob_rsp_accept got %b want 0", bus4.ob_rsp_accept); end
        bus4.req_vld    = 4'h0;
        bus4.ob_rsp_vld = 1'b0;
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] acc_tbl [10];
        int         port_tbl [10];
        acc_tbl  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                     4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        port_tbl = '{0, 0, 0, 1, 0, 2, 0, 3, 0, 0};
        bus4.req_vld = 4'hF;
        for (int c = 0; c < 10; c++) begin
            #1;
            n_cmp++;
            if (bus4.req_accept !== acc_tbl[c]) begin
                n_err++; $display("FAIL rr_accept c=%0d got %b want %b", c, bus4.req_accept, acc_tbl[c]);
            end
            n_cmp++;
            if (bus4.cmd_vld_r !== 1'(c % 2)) begin
                n_err++; $display("FAIL rr_cmd_vld c=%0d got %b want %b", c, bus4.cmd_vld_r, 1'(c % 2));
            end
            if (c % 2 == 1) begin
                n_cmp++;
                if (bus4.cmd_r !== exp_cmd(port_tbl[c])) begin
                    n_err++; $display("FAIL rr_cmd c=%0d got %h want %h", c, bus4.cmd_r, exp_cmd(port_tbl[c]));
                end
            end
            tick();
        end
        bus4.req_vld = 4'h0;
    endtask

    task automatic test_wrap();
        bus4.req_vld = 4'b0100;
        #1;
        n_cmp++; if (bus4.req_accept !== 4'b0100) begin n_err++; $display("FAIL wrap_first got %b want 0100", bus4.req_accept); end
        tick();
        #1;
        n_cmp++; if (bus4.req_accept !== 4'b0000) begin n_err++; $display("FAIL wrap_spacing got %b want 0000", bus4.req_accept); end
        tick();
        #1;
        n_cmp++; if (bus4.req_accept !== 4'b0100) begin n_err++; $display("FAIL wrap_grant got %b want 0100", bus4.req_accept); end
        tick();
        n_cmp++; if (bus4.cmd_r !== exp_cmd(2)) begin n_err++; $display("FAIL wrap_cmd got %h want %h", bus4.cmd_r, exp_cmd(2)); end
        bus4.req_vld = 4'b1001;
        tick();
        #1;
        n_cmp++; if (bus4.req_accept !== 4'b1000) begin n_err++; $display("FAIL wrap_ptr3 got %b want 1000", bus4.req_accept); end
        tick();
        bus4.req_vld = 4'b0000;
        n_cmp++; if (bus4.cmd_r !== exp_cmd(3)) begin n_err++; $display("FAIL wrap_cmd3 got %h want %h", bus4.cmd_r, exp_cmd(3)); end
        tick();
    endtask

    task automatic test_full();
        bus4.cmd_full_r = 1'b1;
        bus4.req_vld    = 4'b0010;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (bus4.req_accept !== 4'b0 || bus4.cmd_vld_r !== 1'b0) begin
                n_err++; $display("FAIL full_hold c=%0d got acc %b vld %b want 0000 0", c, bus4.req_accept, bus4.cmd_vld_r);
            end
            tick();
        end
        bus4.cmd_full_r = 1'b0;
        #1;
        n_cmp++; if (bus4.req_accept !== 4'b0010) begin n_err++; $display("FAIL full_release got %b want 0010", bus4.req_accept); end
        tick();
        bus4.req_vld = 4'b0000;
        n_cmp++;
        if (bus4.cmd_vld_r !== 1'b1 || bus4.cmd_r !== exp_cmd(1)) begin
            n_err++; $display("FAIL full_cmd got vld %b cmd %h want 1 %h", bus4.cmd_vld_r, bus4.cmd_r, exp_cmd(1));
        end
        tick();
    endtask

    task automatic test_rsp_stall();
        ob_pkg::rsp_t ra, rb, rc;
        ra = '{uid: 8'hC1, status: 2'd1, qty: 16'hAAAA};
        rb = '{uid: 8'h02, status: 2'd2, qty: 16'hBBBB};
        rc = '{uid: 8'h03, status: 2'd3, qty: 16'hCCCC};
        bus4.ob_rsp_vld = 1'b1;
        bus4.ob_rsp     = ra;
        bus4.rsp_accept = 4'b0000;
        #1;
        n_cmp++; if (bus4.ob_rsp_accept !== 1'b1) begin n_err++; $display("FAIL rsp_pop_a got %b want 1", bus4.ob_rsp_accept); end
        tick();
        bus4.ob_rsp = rb;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (bus4.rsp_vld !== 4'b1000 || bus4.rsp !== ra || bus4.ob_rsp_accept !== 1'b0) begin
                n_err++; $display("FAIL rsp_stall c=%0d got vld %b rsp %h acc %b want 1000 %h 0",
                                  c, bus4.rsp_vld, bus4.rsp, bus4.ob_rsp_accept, ra);
            end
            tick();
        end
        bus4.rsp_accept = 4'b1000;
        #1;
        n_cmp++;
        if (bus4.rsp_vld !== 4'b1000 || bus4.ob_rsp_accept !== 1'b1) begin
            n_err++; $display("FAIL rsp_release got vld %b acc %b want 1000 1", bus4.rsp_vld, bus4.ob_rsp_accept);
        end
        tick();
        bus4.ob_rsp     = rc;
        bus4.rsp_accept = 4'b0001;
        #1;
        n_cmp++;
        if (bus4.rsp_vld !== 4'b0001 || bus4.rsp !== rb || bus4.ob_rsp_accept !== 1'b1) begin
            n_err++; $display("FAIL rsp_b2b_b got vld %b rsp %h acc %b want 0001 %h 1", bus4.rsp_vld, bus4.rsp, bus4.ob_rsp_accept, rb);
        end
        tick();
        bus4.ob_rsp_vld = 1'b0;
        #1;
        n_cmp++;
        if (bus4.rsp_vld !== 4'b0001 || bus4.rsp !== rc || bus4.ob_rsp_accept !== 1'b0) begin
            n_err++; $display("FAIL rsp_b2b_c got vld %b rsp %h acc %b want 0001 %h 0", bus4.rsp_vld, bus4.rsp, bus4.ob_rsp_accept, rc);
        end
        tick();
        bus4.rsp_accept = 4'b0000;
        #1;
        n_cmp++; if (bus4.rsp_vld !== 4'b0000) begin n_err++; $display("FAIL rsp_drain got %b want 0000", bus4.rsp_vld); end
    endtask

    task automatic test_bad_port();
        bus3.ob_rsp_vld = 1'b1;
        bus3.ob_rsp     = '{uid: 8'hC5, status: 2'd0, qty: 16'h0BAD};
        #1;
        n_cmp++; if (bus3.ob_rsp_accept !== 1'b1) begin n_err++; $display("FAIL bad_pop got %b want 1", bus3.ob_rsp_accept); end
        tick();
        bus3.ob_rsp_vld = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if (bus3.err_r !== 1'b1 || bus3.rsp_vld !== 3'b000) begin
                n_err++; $display("FAIL bad_err c=%0d got err %b vld %b want 1 000", c, bus3.err_r, bus3.rsp_vld);
            end
            tick();
        end
        bus3.ob_rsp_vld = 1'b1;
        bus3.ob_rsp     = '{uid: 8'h87, status: 2'd1, qty: 16'h0600};
        tick();
        bus3.ob_rsp_vld = 1'b0;
        #1;
        n_cmp++;
        if (bus3.rsp_vld !== 3'b100 || bus3.err_r !== 1'b1) begin
            n_err++; $display("FAIL bad_then_good got vld %b err %b want 100 1", bus3.rsp_vld, bus3.err_r);
        end
        n_cmp++; if (bus4.err_r !== 1'b0) begin n_err++; $display("FAIL err_isolated got %b want 0", bus4.err_r); end
        tick();
    endtask

    task automatic test_reset_midstream();
        bus4.req_vld    = 4'hF;
        bus4.ob_rsp_vld = 1'b1;
        bus4.ob_rsp     = '{uid: 8'h80, status: 2'd2, qty: 16'h7777};
        tick();
        #1;
        n_cmp++;
        if (bus4.cmd_vld_r !== 1'b1 || bus4.rsp_vld !== 4'b0100) begin
            n_err++; $display("FAIL mid_setup got vld %b rsp_vld %b want 1 0100", bus4.cmd_vld_r, bus4.rsp_vld);
        end
        rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (bus4.cmd_vld_r !== 1'b0 || bus4.cmd_r !== '0 || bus4.rsp_vld !== 4'b0 ||
                bus4.rsp !== '0 || bus4.req_accept !== 4'b0 || bus4.ob_rsp_accept !== 1'b0 ||
                bus3.err_r !== 1'b0) begin
                n_err++; $display("FAIL mid_reset c=%0d got vld %b cmd %h rvld %b rsp %h acc %b racc %b err3 %b want all 0",
                                  c, bus4.cmd_vld_r, bus4.cmd_r, bus4.rsp_vld, bus4.rsp,
                                  bus4.req_accept, bus4.ob_rsp_accept, bus3.err_r);
            end
            tick();
        end
        rst             = 1'b0;
        bus4.req_vld    = 4'b1110;
        bus4.ob_rsp_vld = 1'b0;
        #1;
        n_cmp++; if (bus4.req_accept !== 4'b0010) begin n_err++; $display("FAIL mid_first_grant got %b want 0010", bus4.req_accept); end
        tick();
        bus4.req_vld = 4'b0000;
        n_cmp++; if (bus4.cmd_r !== exp_cmd(1)) begin n_err++; $display("FAIL mid_first_cmd got %h want %h", bus4.cmd_r, exp_cmd(1)); end
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus4.req_vld    = '0;
        bus4.cmd_full_r = 1'b0;
        bus4.ob_rsp_vld = 1'b0;
        bus4.ob_rsp     = '0;
        bus4.rsp_accept = '0;
        bus3.req_vld    = '0;
        bus3.cmd_full_r = 1'b0;
        bus3.ob_rsp_vld = 1'b0;
        bus3.ob_rsp     = '0;
        bus3.rsp_accept = '0;
        for (int i = 0; i < 4; i++) bus4.req_cmd[i] = mk_cmd(i);
        for (int i = 0; i < 3; i++) bus3.req_cmd[i] = mk_cmd(i);

        test_reset();
        test_round_robin();
        test_wrap();
        test_full();
        test_rsp_stall();
        test_bad_port();
        test_reset_midstream();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ob_cmd_arb.md
# ob_cmd_arb

Round-robin arbiter that shares the single order-book command port between N independent requesters, such as client sessions or feed handlers. It issues at most one command per two cycles, throttled so the 4-entry ingress queue behind `cmd_full_r` can never overflow. It stamps each command's uid with the requester index. It routes each order-book response back to its requester through a registered output stage. It sits between the session layer and `ob`, and drives `ob`'s `cmd_vld_r`/`cmd_r` and `rsp_accept` directly.

## Interface
- `N`, default 4: number of requesters; legal range 2..16.
- `P_W`, default `$clog2(N)`: port-index width; must not exceed `$bits(ob_pkg::uid_t)`.
- `clk`, input, 1: clock; single clock domain.
- `rst`, input, 1: reset, asynchronous, active-high.
- `req_vld`, input, N: requester i presents a command.
- `req_cmd`, input, N x `ob_pkg::cmd_t`: per-requester command; held stable while `req_vld[i]` is high and not yet accepted.
- `req_accept`, output, N: combinational one-hot grant; the command transfers in the same cycle.
- `cmd_vld_r`, output, 1: registered command valid to `ob`.
- `cmd_r`, output, `ob_pkg::cmd_t`: registered command to `ob`.
- `cmd_full_r`, input, 1: `ob` ingress queue full.
- `ob_rsp_vld`, input, 1: response valid from `ob`.
- `ob_rsp`, input, `ob_pkg::rsp_t`: response from `ob`.
- `ob_rsp_accept`, output, 1: pops the `ob` egress queue.
- `rsp_vld`, output, N: registered one-hot response valid per requester.
- `rsp`, output, `ob_pkg::rsp_t`: registered response, shared by all requesters.
- `rsp_accept`, input, N: requester i consumes `rsp`.
- `err_r`, output, 1: sticky flag; a response carried an out-of-range port index.

## Operation
- Issue eligibility in cycle t: `~cmd_full_r & ~cmd_vld_r`.
  - Only one push is ever in flight, which guarantees no overflow despite the one-cycle lag of `cmd_full_r`.
  - Peak issue rate is one command per 2 cycles.
- Arbitration:
  - A round-robin pointer `ptr_r` (P_W bits) names the highest-priority port.
  - The grant goes to the first i with `req_vld[i]`, scanning `ptr_r`, `ptr_r+1`, ... modulo N.
  - Only when eligible: `req_accept = grant`. When ineligible, `req_accept` is 0.
  - After a grant to port g, `ptr_r` becomes (g+1) mod N. With no grant, `ptr_r` holds.
  - Wrap: for g = N-1, `ptr_r` returns to 0.
- Uid stamping on a grant to g:
  - `cmd_r` is loaded with `req_cmd[g]`, except the uid MSBs `[UID_W-1 -: P_W]` are overwritten with g.
  - `cmd_vld_r` is set for exactly one cycle, then cleared.
  - `cmd_r` holds its last value when idle.
- Response routing:
  - Port p = `ob_rsp.uid[UID_W-1 -: P_W]`.
  - The output stage (`rsp_vld`, `rsp`) has one entry. It is "free" when no bit of `rsp_vld` is set, or when `rsp_accept[p_held]` is high this cycle.
  - `ob_rsp_accept = ob_rsp_vld & free`.
  - On a pop with p < N: load `rsp = ob_rsp` and set `rsp_vld = 1<<p`. The uid is passed through unmodified.
  - On a pop with p >= N (only possible when N is not a power of 2): discard the response, set `err_r`, and clear or keep the output stage per the free rule.
  - Simultaneous accept and new pop: back-to-back, one response per cycle, no bubble.
- The command and response paths are independent and do not stall each other.
- `err_r` is cleared only by `rst`.
- Reset (asynchronous, any cycle, including with a command or response in flight):
  - `cmd_vld_r` = 0, `cmd_r` = 0, `ptr_r` = 0, `rsp_vld` = 0, `rsp` = 0, `err_r` = 0.
  - Any command or response held in flight is dropped.
  - `req_accept` and `ob_rsp_accept` are 0 while `rst` is high.

## Timing
- Grant-to-`cmd_vld_r` latency: 1 cycle. Minimum spacing between issues: 2 cycles.
- `ob_rsp_accept` to `rsp_vld`: 1 cycle.
- Requester accept to next response visible: same-cycle reload.
- Combinational paths:
  - `req_vld` / `cmd_full_r` / `cmd_vld_r` → `req_accept`.
  - `ob_rsp_vld` / `rsp_accept` / `rsp_vld` → `ob_rsp_accept`.
- No combinational path from `ob_rsp` into the command side.

## Test plan
- Reset, then all four ports request continuously with `cmd_full_r` = 0.
  - Grants go 0,1,2,3,0 on cycles 0,2,4,6,8.
  - `cmd_vld_r` is high on cycles 1,3,5,7,9.
  - `cmd_r.uid` top 2 bits equal 0,1,2,3,0.
- Only port 2 requests, with `ptr_r` = 3.
  - Port 2 is granted after wrap; `ptr_r` becomes 3.
- `cmd_full_r` rises while port 1 is pending.
  - No `req_accept` while full.
  - Port 1 is granted in the first cycle after both `cmd_full_r` = 0 and `cmd_vld_r` = 0.
  - The ingress queue never sees a push while full.
- `ob` presents responses with uid MSBs 3, 0, 0 on consecutive cycles; port 3 stalls `rsp_accept` for 2 cycles.
  - `rsp_vld` = 4'b1000 is held for 3 cycles.
  - `ob_rsp_accept` stays low during the stall.
  - Port 0 then receives both responses on consecutive cycles.
- N = 3, response uid MSBs = 3.
  - The response is popped and discarded; `err_r` = 1 and stays set.
  - `rsp_vld` stays 0.
- `rst` asserted mid-stream with `cmd_vld_r` = 1 and `rsp_vld` non-zero.
  - All outputs are 0 immediately (asynchronous), and stay 0 until `rst` is released.
  - The first grant after release goes to the lowest-indexed requesting port.
